bullet_datapath: RTL
====================

// Module: bullet_datapath
// PURPOSE
//  Datapath and pixel sequencer for the player bullet. It is driven by the bullet
//  control FSM through inResetState and inUpdatePositionState, and returns
//  updatePosition, topReached and collidedWithEnemy to that FSM. It holds the bullet
//  X/Y position, generates the frame-rate move tick, tests for enemy overlap, and
//  erases/redraws the bullet box on the VGA adapter, one pixel per cycle.
// PARAMETERS
//  TICK_CYCLES   833333  clk cycles per frame (50 MHz / 60)
//  FRAMES_PER_MV 1       frames between updatePosition pulses
//  X_W / Y_W     8 / 7   coordinate widths (160x120 screen)
//  BULLET_W/H    2 / 4   bullet box size, pixels
//  ENEMY_W/H     8 / 8   enemy box size, pixels
//  STEP          2       pixels moved up per update
//  X_OFFSET      3       bullet X offset from ship_x at launch
//  COLOUR        3'b111  bullet colour (erase colour is 3'b000)
// PORTS
//  clk                   in   1    system clock
//  resetn                in   1    synchronous, active-low reset
//  inResetState          in   1    FSM in reset state: load launch position
//  inUpdatePositionState in   1    FSM in update state (exactly 1 cycle wide)
//  ship_x / ship_y       in   X_W/Y_W  ship top-left corner
//  enemy_x / enemy_y     in   X_W/Y_W  enemy top-left corner
//  enemy_alive           in   1    enemy box valid for collision
//  updatePosition        out  1    1-cycle move request to FSM
//  topReached            out  1    bullet cannot move further up
//  collidedWithEnemy     out  1    bullet box overlaps enemy box
//  bullet_x / bullet_y   out  X_W/Y_W  current bullet top-left corner
//  vga_x / vga_y         out  X_W/Y_W  pixel address
//  vga_colour            out  3    pixel colour
//  vga_plot              out  1    pixel write strobe
//  busy                  out  1    sequencer not in IDLE
// BEHAVIOUR
//  Reset (resetn=0 at posedge): all registers and outputs 0, sequencer IDLE,
//   tick counter 0, no pending tick. Takes effect mid-draw; vga_plot is 0 the next cycle.
//  Tick: a free-running counter wraps every TICK_CYCLES*FRAMES_PER_MV cycles and sets
//   a pending flag. updatePosition = pending & !busy, 1 cycle; this clears pending.
//   A tick arriving while pending is already set is dropped.
//  Launch: every cycle with inResetState=1, bullet_x <= ship_x + X_OFFSET and
//   bullet_y <= ship_y - BULLET_H (modulo 2^Y_W). Nothing is drawn.
//  topReached = inUpdatePositionState & (bullet_y < STEP), combinational.
//  collidedWithEnemy = inUpdatePositionState & enemy_alive & box overlap, combinational.
//   Overlap means bx < ex+ENEMY_W, ex < bx+BULLET_W, by < ey+ENEMY_H and ey < by+BULLET_H.
//   Compare at X_W+1 / Y_W+1 bits so there is no wrap.
//  Update edge (inUpdatePositionState=1):
//   - Both flags 0: old_x/old_y <= bullet pos; bullet_y <= bullet_y - STEP;
//     mode <= MOVE; seq -> ERASE.
//   - topReached or collided: position unchanged; old pos latched; mode <= KILL;
//     seq -> ERASE.
//  Sequencer states and transitions:
//   - IDLE -> ERASE -> (MOVE ? DRAW : IDLE) -> IDLE.
//   - ERASE: plots BULLET_W*BULLET_H pixels at old pos in colour 0.
//   - DRAW: plots the same count at the new bullet pos in COLOUR.
//   - Pixel order is row-major: dx fastest, then dy. vga_x = base_x+dx, vga_y = base_y+dy.
//   - vga_plot=1 on every ERASE/DRAW cycle, with no gaps.
//   - A MOVE takes 2*BULLET_W*BULLET_H consecutive plot cycles; a KILL takes half that.
//  inResetState during ERASE: the launch load proceeds, and the erase still uses old pos.
//  inUpdatePositionState while busy is a protocol violation. It is ignored, and the
//   combinational flags still evaluate.
// TESTING  (bench uses TICK_CYCLES=20)
//  1 Release resetn -> all outputs 0; first updatePosition pulse exactly 20 cycles
//    later, then every 20 cycles while idle.
//  2 inResetState with ship=(80,110) -> bullet=(83,106) next cycle; vga_plot stays 0.
//  3 Update pulse at (83,106), no enemy -> bullet_y=104; 8 plots colour 0 over
//    x 83..84, y 106..109, then 8 plots colour 7 over x 83..84, y 104..107; 16 contiguous cycles.
//  4 bullet_y=1, update -> topReached=1 in that cycle, bullet_y stays 1, 8 erase plots only.
//  5 Enemy (82,100) alive, bullet (83,104), update -> collided=1, erase only;
//    same stimulus with enemy_alive=0 -> collided=0, normal move.
//  6 resetn=0 on the 5th plot cycle of a MOVE -> vga_plot=0 and busy=0 on the next
//    cycle; tick counter restarts from 0.

Source files
------------

// File: rtl/bullet_datapath.sv
// Player bullet datapath: holds position, makes the frame tick, tests enemy overlap, erases/redraws one pixel per cycle.
// Move tick is held pending until the sequencer is idle; a move request arriving while busy is ignored.
module bullet_datapath #(
    parameter int         TICK_CYCLES   = 833333,
    parameter int         FRAMES_PER_MV = 1,
    parameter int         X_W           = 8,
    parameter int         Y_W           = 7,
    parameter int         BULLET_W      = 2,
    parameter int         BULLET_H      = 4,
    parameter int         ENEMY_W       = 8,
    parameter int         ENEMY_H       = 8,
    parameter int         STEP          = 2,
    parameter int         X_OFFSET      = 3,
    parameter logic [2:0] COLOUR        = 3'b111
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           inResetState,
    input  logic           inUpdatePositionState,
    input  logic [X_W-1:0] ship_x,
    input  logic [Y_W-1:0] ship_y,
    input  logic [X_W-1:0] enemy_x,
    input  logic [Y_W-1:0] enemy_y,
    input  logic           enemy_alive,
    output logic           updatePosition,
    output logic           topReached,
    output logic           collidedWithEnemy,
    output logic [X_W-1:0] bullet_x,
    output logic [Y_W-1:0] bullet_y,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [2:0]     vga_colour,
    output logic           vga_plot,
    output logic           busy
);

    localparam int PERIOD = TICK_CYCLES * FRAMES_PER_MV;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DXW    = (BULLET_W > 1) ? $clog2(BULLET_W) : 1;
    localparam int DYW    = (BULLET_H > 1) ? $clog2(BULLET_H) : 1;

    localparam logic [X_W:0]   BW_EXT   = (X_W+1)'(BULLET_W);
    localparam logic [X_W:0]   EW_EXT   = (X_W+1)'(ENEMY_W);
    localparam logic [Y_W:0]   BH_EXT   = (Y_W+1)'(BULLET_H);
    localparam logic [Y_W:0]   EH_EXT   = (Y_W+1)'(ENEMY_H);
    localparam logic [X_W-1:0] X_OFS    = X_W'(X_OFFSET);
    localparam logic [Y_W-1:0] BH_Y     = Y_W'(BULLET_H);
    localparam logic [Y_W-1:0] STEP_Y   = Y_W'(STEP);
    localparam logic [CW-1:0]  CNT_LAST = CW'(PERIOD - 1);
    localparam logic [DXW-1:0] DX_LAST  = DXW'(BULLET_W - 1);
    localparam logic [DYW-1:0] DY_LAST  = DYW'(BULLET_H - 1);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW} seq_t;

    seq_t           seq, seq_nxt;
    logic [DXW-1:0] dx, dx_nxt;
    logic [DYW-1:0] dy, dy_nxt;
    logic [CW-1:0]  tick_cnt;
    logic           pending;
    logic           tick_wrap;
    logic           mode_move;
    logic [X_W-1:0] old_x;
    logic [Y_W-1:0] old_y;
    logic           overlap;
    logic           update_go;
    logic           move_ok;
    logic [X_W-1:0] base_x;
    logic [Y_W-1:0] base_y;

    assign tick_wrap      = (tick_cnt == CNT_LAST);
    assign busy           = (seq != IDLE);
    assign updatePosition = pending & ~busy;

    // Widened by one bit so a box at the screen edge cannot wrap into an overlap.
    assign overlap = ({1'b0, bullet_x} < {1'b0, enemy_x} + EW_EXT) &&
                     ({1'b0, enemy_x}  < {1'b0, bullet_x} + BW_EXT) &&
                     ({1'b0, bullet_y} < {1'b0, enemy_y} + EH_EXT) &&
                     ({1'b0, enemy_y}  < {1'b0, bullet_y} + BH_EXT);

    assign topReached        = inUpdatePositionState & (bullet_y < STEP_Y);
    assign collidedWithEnemy = inUpdatePositionState & enemy_alive & overlap;
    assign update_go         = inUpdatePositionState & ~busy;
    assign move_ok           = ~topReached & ~collidedWithEnemy;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            seq       <= IDLE;
            dx        <= '0;
            dy        <= '0;
            tick_cnt  <= '0;
            pending   <= 1'b0;
            mode_move <= 1'b0;
            old_x     <= '0;
            old_y     <= '0;
            bullet_x  <= '0;
            bullet_y  <= '0;
        end else begin
            seq      <= seq_nxt;
            dx       <= dx_nxt;
            dy       <= dy_nxt;
            tick_cnt <= tick_wrap ? '0 : tick_cnt + CW'(1);
            if (tick_wrap && !pending)
                pending <= 1'b1;
            else if (updatePosition)
                pending <= 1'b0;

            if (inResetState) begin
                bullet_x <= ship_x + X_OFS;
                bullet_y <= ship_y - BH_Y;
            end else if (update_go && move_ok) begin
                bullet_y <= bullet_y - STEP_Y;
            end

            if (update_go) begin
                old_x     <= bullet_x;
                old_y     <= bullet_y;
                mode_move <= move_ok;
            end
        end
    end

    always_comb begin
        seq_nxt = seq;
        dx_nxt  = dx;
        dy_nxt  = dy;
        case (seq)
            IDLE: begin
                if (inUpdatePositionState) begin
                    seq_nxt = ERASE;
                    dx_nxt  = '0;
                    dy_nxt  = '0;
                end
            end
            ERASE, DRAW: begin
                if (dx == DX_LAST && dy == DY_LAST) begin
                    dx_nxt  = '0;
                    dy_nxt  = '0;
                    seq_nxt = (seq == ERASE && mode_move) ? DRAW : IDLE;
                end else if (dx == DX_LAST) begin
                    dx_nxt = '0;
                    dy_nxt = dy + DYW'(1);
                end else begin
                    dx_nxt = dx + DXW'(1);
                end
            end
            default: seq_nxt = IDLE;
        endcase
    end

    // Erase paints the latched old box; draw paints the live position.
    always_comb begin
        base_x     = (seq == DRAW) ? bullet_x : old_x;
        base_y     = (seq == DRAW) ? bullet_y : old_y;
        vga_plot   = busy;
        vga_x      = busy ? base_x + X_W'(dx) : '0;
        vga_y      = busy ? base_y + Y_W'(dy) : '0;
        vga_colour = (seq == DRAW) ? COLOUR : 3'b000;
    end

endmodule
